// File: rtl/bcd6_to_bin_pkg.sv
// bcd6_to_bin_pkg: shared widths and FSM encoding for the 6-digit BCD to binary converter.
package bcd6_to_bin_pkg;
    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 4;
    localparam int BIN_W      = 20;
    localparam int CNT_W      = 3;
    localparam int VEC_W      = NUM_DIGITS * DIGIT_W;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/bcd6_to_bin_mac10.sv
// bcd_mac10: combinational acc*10 + digit (acc, digit in; result out).
module bcd_mac10
    import bcd6_to_bin_pkg::*;
(
    input  logic [BIN_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [BIN_W-1:0]   result
);
    // 999999 fits in 20 bits, so truncation of the shifts never loses a valid result
    assign result = (acc << 3) + (acc << 1) + BIN_W'(digit);
endmodule

// File: rtl/bcd6_to_bin.sv
// bcd6_to_bin: sequential 6-digit BCD to 20-bit binary converter
// (clk, ar async reset, start, bcd5..bcd0 digits in; bin, busy, done, err out).
module bcd6_to_bin
    import bcd6_to_bin_pkg::*;
(
    input  logic               clk,
    input  logic               ar,
    input  logic               start,
    input  logic [DIGIT_W-1:0] bcd5,
    input  logic [DIGIT_W-1:0] bcd4,
    input  logic [DIGIT_W-1:0] bcd3,
    input  logic [DIGIT_W-1:0] bcd2,
    input  logic [DIGIT_W-1:0] bcd1,
    input  logic [DIGIT_W-1:0] bcd0,
    output logic [BIN_W-1:0]   bin,
    output logic               busy,
    output logic               done,
    output logic               err
);
    logic [1:0]       state;
    logic [VEC_W-1:0] digits;
    logic [VEC_W-1:0] vec;
    logic [BIN_W-1:0] acc;
    logic [BIN_W-1:0] mac;
    logic [CNT_W-1:0] cnt;
    logic             bad;

    assign digits = {bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};
    assign busy   = state == S_CONV;
    assign done   = state == S_DONE;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            bad = bad | (digits[i*DIGIT_W +: DIGIT_W] > 4'd9);
    end

    // most significant captured digit is always at the top of vec
    bcd_mac10 u_mac (
        .acc    (acc),
        .digit  (vec[VEC_W-1 -: DIGIT_W]),
        .result (mac)
    );

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            state <= S_IDLE;
            vec   <= '0;
            acc   <= '0;
            cnt   <= '0;
            bin   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (bad) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            vec   <= digits;
                            acc   <= '0;
                            cnt   <= '0;
                            err   <= 1'b0;
                            state <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    acc <= mac;
                    vec <= vec << DIGIT_W;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(NUM_DIGITS - 1)) begin
                        bin   <= mac;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/bcd6_to_bin.md
BCD6_TO_BIN -- requirements
Module: bcd6_to_bin

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 ar  input  1  asynchronous active-high reset.
REQ-004 start  input  1  conversion request, sampled on rising clk edge.
REQ-005 bcd5..bcd0  input  4 each  BCD digits; bcd5 is the most significant.
REQ-006 bin  output  20  binary result, registered, held between conversions.
REQ-007 busy  output  1  high while the block is converting.
REQ-008 done  output  1  single-cycle completion pulse.
REQ-009 err  output  1  high when the last accepted request held a non-BCD digit.

Function
REQ-010 SHALL have three states: IDLE, CONV and DONE.
REQ-011 IDLE, start=1, all digits <=9: at edge N, SHALL capture the 24-bit digit vector, clear the accumulator and step counter, clear err, and enter CONV.
REQ-012 IDLE, start=1, any digit >9: at edge N, SHALL set err=1, leave bin unchanged, and enter DONE.
REQ-013 CONV: each edge SHALL compute acc <= acc*10 + (top captured digit), then shift the captured vector left by 4 bits.
REQ-014 acc*10 SHALL be formed as (acc<<3)+(acc<<1) in 20 bits; max 999999 < 2^20, so no overflow or saturation logic is needed.
REQ-015 Six CONV steps SHALL occur, on edges N+1..N+6.
REQ-016 At edge N+6, SHALL load bin with the final acc value and enter DONE.
REQ-017 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE at the next edge.
REQ-018 Valid conversion latency: done high in the cycle after edge N+6.
REQ-019 Invalid request latency: done high in the cycle after edge N.
REQ-020 busy SHALL equal 1 in CONV only; busy and done SHALL never both be high.
REQ-021 start SHALL be ignored in CONV and DONE; no queuing.
REQ-022 Input digits SHALL be ignored after capture; changes during CONV do not affect the result.
REQ-023 err SHALL hold its value until the next accepted start.
REQ-024 Back-to-back operation: start=1 held continuously SHALL give one conversion every 8 cycles (IDLE, 6 x CONV, DONE).

Reset
REQ-025 ar=1 SHALL immediately force IDLE, bin=0, busy=0, done=0, err=0, acc=0, counter=0, independent of clk.
REQ-026 ar asserted mid-conversion SHALL abort the conversion with no done pulse.
REQ-027 The first start after ar deasserts SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold: NUM_DIGITS=6, DIGIT_W=4, BIN_W=20, the state encoding (IDLE/CONV/DONE), and the step-counter width (3).
REQ-029 One combinational sub-module, bcd_mac10, SHALL compute acc*10+digit (20-bit in, 4-bit in, 20-bit out).
REQ-030 The digit-validity check and the FSM SHALL reside in bcd6_to_bin.

Verification
REQ-031 Digits 0,0,0,0,0,0 -> bin=0x00000, err=0, done 7 cycles after start.
REQ-032 Digits 9,9,9,9,9,9 -> bin=0xF423F (999999), err=0.
REQ-033 Digits 1,2,3,4,5,6 -> bin=0x1E240 (123456); change inputs to 9s during CONV -> result still 0x1E240.
REQ-034 Prior bin=0x1E240, then bcd2=0xA -> done 1 cycle after start, err=1, bin stays 0x1E240; next valid start clears err.
REQ-035 start pulsed at CONV step 3 -> ignored, single done, correct result; start held high -> done every 8 cycles.
REQ-036 ar pulsed at CONV step 4 -> outputs zero immediately, no done; next start with 0,0,0,0,4,2 -> bin=42.
